// File: rtl/user_obi_demux_err_if.sv
`default_nettype none
// ============================================================================
// Module   : user_obi_demux_err_if
// Brief    : OBI request/response bundle with manager and subordinate views.
// Revision : 1.0
// ============================================================================
interface user_obi_demux_err_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [ID_WIDTH-1:0]     aid;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;
    logic [ID_WIDTH-1:0]     rid;

    modport master (
        output req, addr, we, be, wdata, aid,
        input  gnt, rvalid, rdata, err, rid
    );

    modport slave (
        input  req, addr, we, be, wdata, aid,
        output gnt, rvalid, rdata, err, rid
    );
endinterface
`default_nettype wire

// File: rtl/user_obi_demux_err.sv
`default_nettype none
// ============================================================================
// Module   : user_obi_demux_err
// Brief    : OBI demux to NUM_PORTS user subordinates with address decode,
//            in-order outstanding tracking and an internal error responder.
// Revision : 1.0
// ============================================================================
module user_obi_demux_err #(
    parameter int unsigned          ADDR_WIDTH    = 32,
    parameter int unsigned          DATA_WIDTH    = 32,
    parameter int unsigned          ID_WIDTH      = 4,
    parameter int unsigned          NUM_PORTS     = 2,
    parameter int unsigned          NUM_RULES     = 2,
    parameter int unsigned          NUM_MAX_TRANS = 2,
    parameter logic [DATA_WIDTH-1:0] RSP_DATA     = 32'hBADCAB1E
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    user_obi_demux_err_if.slave         sbr_obi_bus,
    input  wire logic [31:0]            addr_map_idx_i   [NUM_RULES],
    input  wire logic [ADDR_WIDTH-1:0]  addr_map_start_i [NUM_RULES],
    input  wire logic [ADDR_WIDTH-1:0]  addr_map_end_i   [NUM_RULES],
    user_obi_demux_err_if.master        mgr_obi_bus [NUM_PORTS],
    input  wire logic                   err_clear_i,
    output logic                        err_valid_o,
    output logic [ADDR_WIDTH-1:0]       err_addr_o,
    output logic [15:0]                 err_count_o
);
    localparam int unsigned TGT_W = $clog2(NUM_PORTS + 1);
    localparam int unsigned CNT_W = $clog2(NUM_MAX_TRANS + 1);
    localparam logic [TGT_W-1:0] ERR_IDX  = TGT_W'(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_MAX_TRANS);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TGT_W-1:0]      sel_q, sel_d;
    logic                  err_rvalid_q, err_rvalid_d;
    logic [ID_WIDTH-1:0]   err_rid_q, err_rid_d;
    logic                  err_valid_q, err_valid_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [15:0]           err_count_q, err_count_d;

    logic [TGT_W-1:0]      w_target;
    logic                  w_hit;
    logic                  w_issue_ok;
    logic                  w_gnt;
    logic                  w_accept;
    logic                  w_err_accept;
    logic                  w_rsp_valid;

    // Index NUM_PORTS of these vectors is the internal error responder.
    logic [NUM_PORTS:0]    w_port_gnt;
    logic [NUM_PORTS:0]    w_port_rvalid;
    logic [NUM_PORTS:0]    w_port_err;
    logic [DATA_WIDTH-1:0] w_port_rdata [NUM_PORTS+1];
    logic [ID_WIDTH-1:0]   w_port_rid   [NUM_PORTS+1];

    always_comb begin
        w_target = ERR_IDX;
        w_hit    = 1'b0;
        for (int r = 0; r < int'(NUM_RULES); r++) begin
            if (!w_hit && (sbr_obi_bus.addr >= addr_map_start_i[r]) &&
                (sbr_obi_bus.addr < addr_map_end_i[r])) begin
                w_hit = 1'b1;
                if (addr_map_idx_i[r] < NUM_PORTS) begin
                    w_target = TGT_W'(addr_map_idx_i[r]);
                end
            end
        end
    end

    // Switching targets only when idle keeps responses in issue order.
    assign w_issue_ok   = (cnt_q == '0) || ((w_target == sel_q) && (cnt_q < CNT_MAX));
    assign w_gnt        = rst_ni & w_issue_ok & w_port_gnt[w_target];
    assign w_accept     = sbr_obi_bus.req & w_gnt;
    assign w_err_accept = w_accept & (w_target == ERR_IDX);
    assign w_rsp_valid  = (cnt_q != '0) & w_port_rvalid[sel_q];

    generate
        for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
            assign mgr_obi_bus[p].req   = rst_ni & w_issue_ok & sbr_obi_bus.req &
                                          (w_target == TGT_W'(p));
            assign mgr_obi_bus[p].addr  = sbr_obi_bus.addr;
            assign mgr_obi_bus[p].we    = sbr_obi_bus.we;
            assign mgr_obi_bus[p].be    = sbr_obi_bus.be;
            assign mgr_obi_bus[p].wdata = sbr_obi_bus.wdata;
            assign mgr_obi_bus[p].aid   = sbr_obi_bus.aid;
            assign w_port_gnt[p]        = mgr_obi_bus[p].gnt;
            assign w_port_rvalid[p]     = mgr_obi_bus[p].rvalid;
            assign w_port_err[p]        = mgr_obi_bus[p].err;
            assign w_port_rdata[p]      = mgr_obi_bus[p].rdata;
            assign w_port_rid[p]        = mgr_obi_bus[p].rid;
        end
    endgenerate

    assign w_port_gnt[NUM_PORTS]    = 1'b1;
    assign w_port_rvalid[NUM_PORTS] = err_rvalid_q;
    assign w_port_err[NUM_PORTS]    = 1'b1;
    assign w_port_rdata[NUM_PORTS]  = RSP_DATA;
    assign w_port_rid[NUM_PORTS]    = err_rid_q;

    assign sbr_obi_bus.gnt    = w_gnt;
    assign sbr_obi_bus.rvalid = w_rsp_valid;
    assign sbr_obi_bus.rdata  = w_rsp_valid ? w_port_rdata[sel_q] : '0;
    assign sbr_obi_bus.err    = w_rsp_valid & w_port_err[sel_q];
    assign sbr_obi_bus.rid    = w_rsp_valid ? w_port_rid[sel_q] : '0;

    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        err_rvalid_d = w_err_accept;
        err_rid_d    = w_err_accept ? sbr_obi_bus.aid : err_rid_q;
        if (w_accept) begin
            sel_d = w_target;
        end
        case ({w_accept, w_rsp_valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Clear is applied first so a same-cycle error access lands in fresh state.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (err_clear_i) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_count_d = '0;
        end
        if (w_err_accept) begin
            if (!err_valid_d) begin
                err_valid_d = 1'b1;
                err_addr_d  = sbr_obi_bus.addr;
            end
            if (err_count_d != 16'hFFFF) begin
                err_count_d = err_count_d + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            sel_q        <= '0;
            err_rvalid_q <= 1'b0;
            err_rid_q    <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_count_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            err_rvalid_q <= err_rvalid_d;
            err_rid_q    <= err_rid_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_count_o = err_count_q;
endmodule
`default_nettype wire
